// File: rtl/reg_file_2r1w_pkg.sv
// Shared definitions for the two-read / one-write register file:
// controller state encoding and the default geometry.
`timescale 1ns/1ps

package reg_file_2r1w_pkg;

    // Default geometry; INDEX_SIZE must equal clog2(NUM_REG).
    localparam int DEFAULT_WORD_SIZE  = 8;
    localparam int DEFAULT_NUM_REG    = 16;
    localparam int DEFAULT_INDEX_SIZE = 4;

    // Controller state: normal operation, or sweeping every register to zero.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } rf_state_e;

endpackage

// File: rtl/reg_file_2r1w_if.sv
// Bus bundle between a register-file client (master) and the register
// file itself (slave): one write port, two read ports, clear control.
`timescale 1ns/1ps

interface reg_file_2r1w_if
    import reg_file_2r1w_pkg::*;
#(
    parameter int WORD_SIZE  = DEFAULT_WORD_SIZE,
    parameter int INDEX_SIZE = DEFAULT_INDEX_SIZE
);

    // Write port
    logic                  write_enable;
    logic [INDEX_SIZE-1:0] write_address;
    logic [WORD_SIZE-1:0]  write_data;

    // Read port A
    logic                  rd_en_a;
    logic [INDEX_SIZE-1:0] read_address_a;
    logic [WORD_SIZE-1:0]  read_data_a;
    logic                  rd_valid_a;

    // Read port B
    logic                  rd_en_b;
    logic [INDEX_SIZE-1:0] read_address_b;
    logic [WORD_SIZE-1:0]  read_data_b;
    logic                  rd_valid_b;

    // Clear control
    logic                  clear_req;
    logic                  busy;

    // Register-file side
    modport slave (
        input  write_enable,
        input  write_address,
        input  write_data,
        input  rd_en_a,
        input  read_address_a,
        output read_data_a,
        output rd_valid_a,
        input  rd_en_b,
        input  read_address_b,
        output read_data_b,
        output rd_valid_b,
        input  clear_req,
        output busy
    );

    // Client side
    modport master (
        output write_enable,
        output write_address,
        output write_data,
        output rd_en_a,
        output read_address_a,
        input  read_data_a,
        input  rd_valid_a,
        output rd_en_b,
        output read_address_b,
        input  read_data_b,
        input  rd_valid_b,
        output clear_req,
        input  busy
    );

endinterface

// File: rtl/reg_file_2r1w_read_port.sv
// One registered read port of the register file. The read result is
// captured on the edge that samples rd_en; a write landing on the same
// register at that same edge is forwarded so the reader sees the new word.
`timescale 1ns/1ps

module rf_read_port
    import reg_file_2r1w_pkg::*;
#(
    parameter int WORD_SIZE  = DEFAULT_WORD_SIZE,
    parameter int NUM_REG    = DEFAULT_NUM_REG,
    parameter int INDEX_SIZE = DEFAULT_INDEX_SIZE
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rd_en,
    input  logic [INDEX_SIZE-1:0] rd_addr,
    input  logic [WORD_SIZE-1:0]  regs [NUM_REG],
    input  logic                  wr_fire,
    input  logic [INDEX_SIZE-1:0] wr_addr,
    input  logic [WORD_SIZE-1:0]  wr_data,
    output logic [WORD_SIZE-1:0]  rd_data,
    output logic                  rd_valid
);

    logic [WORD_SIZE-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 bypass;

    // Forward only a write that really commits this edge (wr_fire already
    // excludes writes dropped during a clear sweep).
    assign bypass = wr_fire && (wr_addr == rd_addr);

    // Next read result: new word on a request, otherwise hold the last one.
    always_comb begin
        data_d  = data_q;
        valid_d = 1'b0;
        if (rd_en) begin
            valid_d = 1'b1;
            data_d  = bypass ? wr_data : regs[rd_addr];
        end
    end

    // Output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign rd_data  = data_q;
    assign rd_valid = valid_q;

endmodule

// File: rtl/reg_file_2r1w.sv
// Two-read / one-write register file with a sequential clear engine.
// A clear request walks a counter over every register, zeroing one per
// cycle; writes are dropped while the sweep runs, reads keep working.
`timescale 1ns/1ps

module reg_file_2r1w
    import reg_file_2r1w_pkg::*;
#(
    parameter int WORD_SIZE  = DEFAULT_WORD_SIZE,
    parameter int NUM_REG    = DEFAULT_NUM_REG,
    parameter int INDEX_SIZE = DEFAULT_INDEX_SIZE
) (
    input  logic             clk,
    input  logic             reset_n,
    reg_file_2r1w_if.slave   bus
);

    localparam logic [INDEX_SIZE-1:0] LAST_IDX = INDEX_SIZE'(NUM_REG - 1);

    rf_state_e             state_q, state_d;
    logic [INDEX_SIZE-1:0] cnt_q, cnt_d;
    logic [WORD_SIZE-1:0]  regs_q [NUM_REG];
    logic [WORD_SIZE-1:0]  regs_d [NUM_REG];

    logic                  clearing;
    logic                  wr_fire;
    logic [NUM_REG-1:0]    wr_hit;
    logic [NUM_REG-1:0]    clr_hit;

    assign clearing = (state_q == CLEAR);
    // A write commits only while idle; in CLEAR it is silently discarded.
    assign wr_fire  = bus.write_enable && (state_q == IDLE);
    assign bus.busy = clearing;

    // Per-register one-hot decode of the write target and the clear cursor.
    for (genvar gi = 0; gi < NUM_REG; gi++) begin : g_decode
        assign wr_hit[gi]  = wr_fire  && (bus.write_address == INDEX_SIZE'(gi));
        assign clr_hit[gi] = clearing && (cnt_q == INDEX_SIZE'(gi));
    end

    // Controller next state: start a sweep from index 0, leave after the last.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.clear_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + INDEX_SIZE'(1);
                if (cnt_q == LAST_IDX) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // Controller registers; reset aborts any sweep in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Register next values: the sweep cursor wins, then a committed write.
    always_comb begin
        for (int i = 0; i < NUM_REG; i++) begin
            regs_d[i] = regs_q[i];
            if (clr_hit[i]) begin
                regs_d[i] = '0;
            end else if (wr_hit[i]) begin
                regs_d[i] = bus.write_data;
            end
        end
    end

    // Storage, cleared asynchronously so reset takes effect at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REG; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    rf_read_port #(
        .WORD_SIZE  (WORD_SIZE),
        .NUM_REG    (NUM_REG),
        .INDEX_SIZE (INDEX_SIZE)
    ) u_read_a (
        .clk      (clk),
        .reset_n  (reset_n),
        .rd_en    (bus.rd_en_a),
        .rd_addr  (bus.read_address_a),
        .regs     (regs_q),
        .wr_fire  (wr_fire),
        .wr_addr  (bus.write_address),
        .wr_data  (bus.write_data),
        .rd_data  (bus.read_data_a),
        .rd_valid (bus.rd_valid_a)
    );

    rf_read_port #(
        .WORD_SIZE  (WORD_SIZE),
        .NUM_REG    (NUM_REG),
        .INDEX_SIZE (INDEX_SIZE)
    ) u_read_b (
        .clk      (clk),
        .reset_n  (reset_n),
        .rd_en    (bus.rd_en_b),
        .rd_addr  (bus.read_address_b),
        .regs     (regs_q),
        .wr_fire  (wr_fire),
        .wr_addr  (bus.write_address),
        .wr_data  (bus.write_data),
        .rd_data  (bus.read_data_b),
        .rd_valid (bus.rd_valid_b)
    );

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench for reg_file_2r1w. The driver issues one cycle of stimulus
// per call and queues the hand-computed read result per port; a monitor
// one step after every rising edge pops and compares.
`timescale 1ns/1ps

module tb_reg_file_2r1w;
    import reg_file_2r1w_pkg::*;

    localparam int W = 8;
    localparam int N = 16;
    localparam int I = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    reg_file_2r1w_if #(.WORD_SIZE(W), .INDEX_SIZE(I)) bus ();

    reg_file_2r1w #(
        .WORD_SIZE  (W),
        .NUM_REG    (N),
        .INDEX_SIZE (I)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] q_a [$];
    logic [W-1:0] q_b [$];
    logic [W-1:0] last_a = '0;
    logic [W-1:0] last_b = '0;

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check8(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: one sample per cycle, away from the rising edge.
    always @(posedge clk) begin
        logic exp_v;
        #1;
        if (!reset_n) begin
            q_a.delete();
            q_b.delete();
            last_a = '0;
            last_b = '0;
            check1("rst_valid_a", bus.rd_valid_a, 1'b0);
            check1("rst_valid_b", bus.rd_valid_b, 1'b0);
            check8("rst_data_a", bus.read_data_a, '0);
            check8("rst_data_b", bus.read_data_b, '0);
        end else begin
            exp_v = (q_a.size() != 0);
            check1("valid_a", bus.rd_valid_a, exp_v);
            if (exp_v) begin
                last_a = q_a.pop_front();
                $display("port A read: data=0x%02h expected=0x%02h", bus.read_data_a, last_a);
            end
            check8("data_a", bus.read_data_a, last_a);

            exp_v = (q_b.size() != 0);
            check1("valid_b", bus.rd_valid_b, exp_v);
            if (exp_v) begin
                last_b = q_b.pop_front();
                $display("port B read: data=0x%02h expected=0x%02h", bus.read_data_b, last_b);
            end
            check8("data_b", bus.read_data_b, last_b);
        end
    end

    // One cycle of stimulus starting at a falling edge; returns at the next one.
    task automatic drive(input int we, input int wa, input int wd,
                         input int ea, input int aa, input int xa,
                         input int eb, input int ab, input int xb,
                         input int clr);
        bus.write_enable   = (we != 0);
        bus.write_address  = I'(wa);
        bus.write_data     = W'(wd);
        bus.rd_en_a        = (ea != 0);
        bus.read_address_a = I'(aa);
        bus.rd_en_b        = (eb != 0);
        bus.read_address_b = I'(ab);
        bus.clear_req      = (clr != 0);
        if (ea != 0) q_a.push_back(W'(xa));
        if (eb != 0) q_b.push_back(W'(xb));
        @(negedge clk);
        bus.write_enable = 1'b0;
        bus.rd_en_a      = 1'b0;
        bus.rd_en_b      = 1'b0;
        bus.clear_req    = 1'b0;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bus.write_enable   = 1'b0;
        bus.write_address  = '0;
        bus.write_data     = '0;
        bus.rd_en_a        = 1'b0;
        bus.read_address_a = '0;
        bus.rd_en_b        = 1'b0;
        bus.read_address_b = '0;
        bus.clear_req      = 1'b0;
        reset_n            = 1'b0;

        repeat (2) @(negedge clk);
        check1("rst_busy", bus.busy, 1'b0);
        reset_n = 1'b1;

        // Fresh registers read as zero on both ports.
        drive(0, 0, 0,    1, 5, 8'h00,  1, 9, 8'h00,  0);
        nop();
        // Plain write then read; port B stays quiet.
        drive(1, 3, 8'hA5, 0, 0, 0,     0, 0, 0,      0);
        drive(0, 0, 0,    1, 3, 8'hA5,  0, 0, 0,      0);
        nop();
        // Same-edge write and dual read of one address: both see new data.
        drive(1, 7, 8'h3C, 1, 7, 8'h3C, 1, 7, 8'h3C,  0);
        // Bypass only on address match.
        drive(1, 0, 8'h5A, 1, 3, 8'hA5, 1, 0, 8'h5A,  0);
        // Top index.
        drive(1, 15, 8'hEE, 0, 0, 0,    0, 0, 0,      0);
        drive(0, 0, 0,    1, 15, 8'hEE, 1, 0, 8'h5A,  0);

        // Fill every register with 0x11, reading back along the way.
        for (int i = 0; i < N; i++) begin
            drive(1, i, 8'h11, (i > 0) ? 1 : 0, (i > 0) ? i - 1 : 0, 8'h11,
                  1, i, 8'h11, 0);
        end

        // Start a clear sweep (the read this cycle is still ordinary).
        drive(0, 0, 0, 1, 7, 8'h11, 0, 0, 0, 1);

        // Sixteen sweep cycles; cycle i zeroes register i at its closing edge.
        for (int i = 0; i < N; i++) begin
            check1("busy_sweep", bus.busy, 1'b1);
            case (i)
                2:  drive(1, 15, 8'hFF, 1, 15, 8'h11, 0, 0, 0,     0);
                3:  drive(0, 0, 0,      1, 0, 8'h00,  1, 3, 8'h11, 0);
                4:  drive(1, 1, 8'hFF,  1, 1, 8'h00,  0, 0, 0,     0);
                5:  drive(0, 0, 0,      0, 0, 0,      1, 15, 8'h11, 0);
                8:  drive(0, 0, 0,      1, 8, 8'h11,  1, 7, 8'h00, 1);
                15: drive(0, 0, 0,      1, 15, 8'h11, 1, 14, 8'h00, 0);
                default: nop();
            endcase
        end
        check1("busy_after_sweep", bus.busy, 1'b0);
        // Register 15 now zero; the dropped 0xFF to register 1 left no trace.
        drive(0, 0, 0, 1, 15, 8'h00, 1, 1, 8'h00, 0);

        // Second sweep started together with a write, then aborted by reset.
        drive(1, 12, 8'h12, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 2, 8'h99,  0, 0, 0, 1, 12, 8'h12, 1);
        for (int i = 0; i < 5; i++) begin
            check1("busy_sweep2", bus.busy, 1'b1);
            case (i)
                0:  drive(0, 0, 0, 1, 2, 8'h99, 0, 0, 0,      0);
                4:  drive(0, 0, 0, 0, 0, 0,     1, 12, 8'h12, 0);
                default: nop();
            endcase
        end
        check1("busy_cycle6", bus.busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check1("busy_async_reset", bus.busy, 1'b0);
        check8("data_a_async_reset", bus.read_data_a, 8'h00);
        check8("data_b_async_reset", bus.read_data_b, 8'h00);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // First edge after release must behave as IDLE: the write lands.
        check1("busy_after_release", bus.busy, 1'b0);
        drive(1, 2, 8'h42, 0, 0, 0,     1, 12, 8'h00, 0);
        check1("busy_idle", bus.busy, 1'b0);
        drive(0, 0, 0,     1, 2, 8'h42, 1, 3, 8'h00,  0);
        nop();
        nop();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
